// File: rtl/sample_mem_scheduler.sv
// Per-sample SRAM time-share sequencer: delay read/write, loop read/write, then publish.
// Optional overdub mixing is compiled in with `define SCHED_OVERDUB_EN.
//
// state   | meaning
// --------+-----------------------------------------------
// IDLE    | waiting for an adc_clock rising edge
// D_RD    | issue delay-tap read
// D_CAP   | capture delay-tap sample from dout0
// D_WR    | write latched sample into delay region
// L_RD    | issue loop playback read
// L_CAP   | capture loop sample from dout0
// L_WR    | write record (or overdub mix) into loop region
// DONE    | pulse out_valid, advance pointers
module sample_mem_scheduler #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              adc_clock,
    input  logic              delay_en,
    input  logic [ADDR_W-2:0] delay_len,
    input  logic              record,
    input  logic              loop,
    input  logic [DATA_W-1:0] sample_in,
    output logic [DATA_W-1:0] delay_out,
    output logic [DATA_W-1:0] loop_out,
    output logic              out_valid,
    output logic              busy,
    output logic              overrun,
    output logic              csb0,
    output logic              web0,
    output logic [ADDR_W-1:0] addr0,
    output logic [DATA_W-1:0] din0,
    input  logic [DATA_W-1:0] dout0
);

    localparam int PW = ADDR_W - 1;

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_D_RD  = 3'd1;
    localparam logic [2:0] S_D_CAP = 3'd2;
    localparam logic [2:0] S_D_WR  = 3'd3;
    localparam logic [2:0] S_L_RD  = 3'd4;
    localparam logic [2:0] S_L_CAP = 3'd5;
    localparam logic [2:0] S_L_WR  = 3'd6;
    localparam logic [2:0] S_DONE  = 3'd7;

    localparam logic [PW-1:0]     P_ONE    = {{(PW-1){1'b0}}, 1'b1};
    localparam logic [PW-1:0]     P_MAX    = {PW{1'b1}};
    localparam logic [ADDR_W-1:0] L_ONE    = {{(ADDR_W-1){1'b0}}, 1'b1};
    localparam logic [ADDR_W-1:0] LEN_FULL = {1'b1, {PW{1'b0}}};

    logic [2:0]        state;
    logic [2:0]        next_state;
    logic              adc_q;
    logic [DATA_W-1:0] sample_q;
    logic [PW-1:0]     dlen_q;
    logic              run_dly;
    logic              run_lrd;
    logic              run_lwr;
    logic              rec_q;
    logic              rec_prev;
    logic              od_q;
    logic [PW-1:0]     dptr;
    logic [PW-1:0]     lptr;
    logic [ADDR_W-1:0] loop_len;

    logic              strobe;
    logic              accept;
    logic              rec_rise;
    logic              rec_clear;
    logic              restart;
    logic [ADDR_W-1:0] len_eff;
    logic              lrd_now;
    logic              od_now;
    logic [PW-1:0]     d_rd_ptr;
    logic [ADDR_W-1:0] lptr_inc;
    logic [DATA_W-1:0] loop_wdata;

    assign strobe    = adc_clock & ~adc_q;
    assign accept    = strobe && (state == S_IDLE);
    assign rec_rise  = record & ~rec_prev;
    // A finished plain recording leaves lptr at loop_len; playback restarts from the top.
    assign restart   = ~record && ({1'b0, lptr} >= loop_len);
    assign len_eff   = rec_clear ? '0 : loop_len;
    assign d_rd_ptr  = dptr - dlen_q;
    assign lptr_inc  = {1'b0, lptr} + L_ONE;
    assign busy      = (state != S_IDLE);
    assign out_valid = (state == S_DONE);

`ifdef SCHED_OVERDUB_EN
    logic [DATA_W:0] od_sum;

    assign rec_clear = rec_rise && !(loop && (loop_len != '0));
    assign lrd_now   = loop && (len_eff != '0);
    assign od_now    = record && lrd_now;
    assign od_sum    = {loop_out[DATA_W-1], loop_out} + {sample_q[DATA_W-1], sample_q};

    always_comb begin
        loop_wdata = sample_q;
        if (od_q) begin
            if (od_sum[DATA_W] != od_sum[DATA_W-1])
                loop_wdata = od_sum[DATA_W] ? {1'b1, {(DATA_W-1){1'b0}}}
                                            : {1'b0, {(DATA_W-1){1'b1}}};
            else
                loop_wdata = od_sum[DATA_W-1:0];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            od_q <= 1'b0;
        else if (accept)
            od_q <= od_now;
    end
`else
    assign rec_clear  = rec_rise;
    assign lrd_now    = loop && !record && (len_eff != '0);
    assign od_now     = 1'b0;
    assign od_q       = od_now;
    assign loop_wdata = sample_q;
`endif

    always_comb begin
        next_state = state;
        case (state)
            S_IDLE: begin
                if (accept) begin
                    if (delay_en)     next_state = S_D_RD;
                    else if (lrd_now) next_state = S_L_RD;
                    else if (record)  next_state = S_L_WR;
                    else              next_state = S_DONE;
                end
            end
            S_D_RD:  next_state = S_D_CAP;
            S_D_CAP: next_state = S_D_WR;
            S_D_WR: begin
                if (run_lrd)      next_state = S_L_RD;
                else if (run_lwr) next_state = S_L_WR;
                else              next_state = S_DONE;
            end
            S_L_RD:  next_state = S_L_CAP;
            S_L_CAP: next_state = run_lwr ? S_L_WR : S_DONE;
            S_L_WR:  next_state = S_DONE;
            S_DONE:  next_state = S_IDLE;
            default: next_state = S_IDLE;
        endcase
    end

    // Port decode is purely from state so reset idles the SRAM without waiting for a clock.
    always_comb begin
        csb0  = 1'b1;
        web0  = 1'b1;
        addr0 = '0;
        din0  = '0;
        case (state)
            S_D_RD: begin
                csb0  = 1'b0;
                addr0 = {1'b0, d_rd_ptr};
            end
            S_D_WR: begin
                csb0  = 1'b0;
                web0  = 1'b0;
                addr0 = {1'b0, dptr};
                din0  = sample_q;
            end
            S_L_RD: begin
                csb0  = 1'b0;
                addr0 = {1'b1, lptr};
            end
            S_L_WR: begin
                csb0  = 1'b0;
                web0  = 1'b0;
                addr0 = {1'b1, lptr};
                din0  = loop_wdata;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= S_IDLE;
            adc_q     <= 1'b0;
            sample_q  <= '0;
            dlen_q    <= '0;
            run_dly   <= 1'b0;
            run_lrd   <= 1'b0;
            run_lwr   <= 1'b0;
            rec_q     <= 1'b0;
            rec_prev  <= 1'b0;
            dptr      <= '0;
            lptr      <= '0;
            loop_len  <= '0;
            delay_out <= '0;
            loop_out  <= '0;
            overrun   <= 1'b0;
        end else begin
            adc_q <= adc_clock;
            state <= next_state;
            if (strobe && (state != S_IDLE))
                overrun <= 1'b1;

            if (accept) begin
                sample_q <= sample_in;
                dlen_q   <= delay_len;
                run_dly  <= delay_en;
                run_lrd  <= lrd_now;
                run_lwr  <= record;
                rec_q    <= record;
                rec_prev <= record;
                if (!delay_en)
                    delay_out <= '0;
                if (!lrd_now)
                    loop_out <= '0;
                if (rec_clear) begin
                    lptr     <= '0;
                    loop_len <= '0;
                end else if (restart) begin
                    lptr <= '0;
                end
            end

            if (state == S_D_CAP)
                delay_out <= dout0;
            if (state == S_L_CAP)
                loop_out <= dout0;

            if (state == S_DONE) begin
                if (run_dly)
                    dptr <= dptr + P_ONE;
                if (rec_q && !od_q) begin
                    if (lptr == P_MAX) begin
                        lptr     <= '0;
                        loop_len <= LEN_FULL;
                    end else begin
                        lptr     <= lptr + P_ONE;
                        loop_len <= (loop_len == LEN_FULL) ? LEN_FULL : lptr_inc;
                    end
                end else if (run_lrd) begin
                    if (lptr_inc == loop_len)
                        lptr <= '0;
                    else
                        lptr <= lptr + P_ONE;
                end
            end
        end
    end

endmodule

// File: doc/sample_mem_scheduler.md
# sample_mem_scheduler

Per-sample sequencer that time-shares the single-port sample SRAM between the delay/reverb line and the looper. On each rising edge of the sample strobe `adc_clock` it runs a fixed access schedule: delay read, delay write, loop read, loop write. It maintains both circular pointers, drives the SRAM port, and presents the retrieved delay and loop samples to the mixing path (mux/adder) with a one-cycle valid pulse. It sits between the controller's memory-control outputs and the SRAM macro, replacing direct SRAM wiring in the memory controller.

## Interface
- `ADDR_W`, 8, SRAM address width; the lower half of the address space is the delay region, the upper half is the loop region.
- `DATA_W`, 16, sample width (two's complement).
- `clk` in 1: system clock; all state on rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `adc_clock` in 1: sample strobe, synchronous to `clk`; a rising edge starts one schedule.
- `delay_en` in 1: enables the delay read/write pair.
- `delay_len` in ADDR_W-1: delay tap distance in samples.
- `record` in 1: loop record enable.
- `loop` in 1: loop playback enable.
- `sample_in` in DATA_W: ADC sample, latched on the strobe edge.
- `delay_out` out DATA_W: last delay-tap sample.
- `loop_out` out DATA_W: last loop playback sample.
- `out_valid` out 1: one-cycle pulse when `delay_out`/`loop_out` update.
- `busy` out 1: high while the schedule is in progress.
- `overrun` out 1: sticky flag; set when a strobe edge arrives while busy.
- `csb0` out 1: SRAM chip select, active-low.
- `web0` out 1: SRAM write enable, active-low.
- `addr0` out ADDR_W: SRAM address.
- `din0` out DATA_W: SRAM write data.
- `dout0` in DATA_W: SRAM read data, valid the cycle after the read is issued.

## Operation
- Reset values: all outputs 0, except `csb0`=1 and `web0`=1. Pointers `dptr`, `lptr` and `loop_len` are 0. State is IDLE.
- Edge detect: `adc_clock` is registered. An edge is declared when the registered value is 0 and the current value is 1.
- States and transitions:
  - IDLE → D_RD on edge; `sample_in` is latched.
  - D_RD → D_CAP → D_WR → L_RD → L_CAP → L_WR → DONE → IDLE.
  - Disabled stages are skipped; the skip chain is evaluated combinationally from IDLE.
- D_RD: read `{1'b0, dptr - delay_len}`, arithmetic mod 2^(ADDR_W-1).
  - `delay_len`=0 reads the slot about to be overwritten, giving the maximum delay of 2^(ADDR_W-1) samples.
- D_CAP: register `dout0` into `delay_out`.
- D_WR: write the latched sample to `{1'b0, dptr}`.
- D_RD/D_CAP/D_WR run only if `delay_en`. If not, `delay_out` holds 0 and `dptr` holds.
- L_RD/L_CAP run only if `loop` and `loop_len` != 0.
  - Address is `{1'b1, lptr}`; the captured value goes to `loop_out`. Otherwise `loop_out` is 0.
- L_WR runs only if `record`; writes to `{1'b1, lptr}`.
- DONE: pulse `out_valid`, then advance pointers:
  - `dptr`+1 if `delay_en`, wrapping mod 2^(ADDR_W-1).
  - While recording: `lptr`+1 and `loop_len`=`lptr`+1. When `lptr` reaches 2^(ADDR_W-1)-1, recording saturates: `lptr` wraps to 0 and `loop_len` stays at full size.
  - Playback only: `lptr`+1, wrapping to 0 when `lptr`+1 == `loop_len`.
- Rising edge of `record` (sampled at the strobe): `lptr`=0, `loop_len`=0 before the schedule runs.
- `record` and `loop` both high: see Configuration.
- Control inputs are sampled once at the strobe edge and held for the whole schedule.
- Overrun: an edge while not IDLE sets `overrun`, and that edge is dropped. `overrun` clears only on reset.
- Reset mid-schedule: an in-flight write is abandoned; the SRAM port returns to idle (`csb0`=1) immediately.

## Timing
- Edge detect to first SRAM access: 1 cycle.
- Full schedule: 7 cycles from edge detect to `out_valid`. The minimum strobe period is therefore 8 `clk` cycles.
- Delay-only or loop-only schedule: 4 cycles.
- Read issued in cycle N (`csb0`=0, `web0`=1); `dout0` is captured at the end of cycle N+1.
- Write cycle: `csb0`=0 and `web0`=0 for exactly one cycle.
- SRAM port is idle (`csb0`=1, `web0`=1) in IDLE, capture states and DONE.

## Configuration
- `SCHED_OVERDUB_EN` defined: with `record` and `loop` both high, L_RD/L_CAP run, and L_WR writes `sat(loop_read + sample)`, saturating to DATA_W signed limits. The loop length is frozen (no `loop_len` update, no reset on the `record` edge when `loop_len` != 0).
- Not defined: `record` has priority. L_RD/L_CAP are skipped, `loop_out`=0, and plain record behaviour applies.

## Test plan
- Reset: hold `rst_n`=0 → `csb0`=1, `web0`=1, all other outputs 0. Release and pulse the strobe with everything disabled → `out_valid` 1 cycle after edge detect, no SRAM access.
- Delay: `delay_en`=1, `delay_len`=3, samples 1,2,3,4,5 → `delay_out` sequence 0,0,0,1,2. Write addresses are 0..4 in the lower half.
- Loop: record 5 samples 10..14, drop `record`, set `loop` → `loop_out` cycles 10,11,12,13,14,10. Read addresses are 0x80..0x84.
- Overrun: second strobe edge 4 cycles after the first, full schedule → `overrun`=1, one `out_valid` only, pointers advance once.
- Wrap: `delay_len`=0 run for 130 samples → `dptr` wraps 127→0 and `delay_out` equals the sample from 128 strobes earlier.
- `SCHED_OVERDUB_EN`: loop holds 0x7000, overdub input 0x2000 → stored value is 0x7FFF (saturated), `loop_len` unchanged.
